// File: rtl/mdu_div_pkg.sv
// Shared definitions for the E-stage divider: operand width, op selects and FSM encoding.
package mdu_div_pkg;

    localparam int unsigned DataWDefault = 32;

    localparam logic OpDivU = 1'b0;
    localparam logic OpDiv  = 1'b1;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StDivZero = 2'b01,
        StOn      = 2'b10,
        StEnd     = 2'b11
    } divState_t;

endpackage

// File: rtl/mdu_div.sv
// Restoring radix-2 divider for the E stage: {remainder, quotient} after 33 cycles,
// or a zero result after 2 cycles on divide-by-zero.
module mdu_div
    import mdu_div_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                signed_i,
    input  logic                annul_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                stall_o
);

    localparam logic [5:0] LastCnt = 6'(DATA_W - 1);

    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        return '0 - v;
    endfunction

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic isSigned);
        return (isSigned && v[DATA_W-1]) ? negate(v) : v;
    endfunction

    divState_t           stateQ, stateD;
    logic [5:0]          cntQ, cntD;
    logic [DATA_W-1:0]   dividendQ, dividendD;
    logic [DATA_W-1:0]   divisorQ, divisorD;
    logic [DATA_W-1:0]   remQ, remD;
    logic                quoNegQ, quoNegD;
    logic                remNegQ, remNegD;
    logic [2*DATA_W-1:0] resultQ, resultD;

    logic                isSigned;
    logic [DATA_W:0]     partial, diff;
    logic [DATA_W-1:0]   quoNext, remNext;

    assign isSigned = (signed_i == OpDiv);

    // One restoring step: the dividend register shifts out its MSB into the partial
    // remainder and shifts the new quotient bit in at the bottom.
    always_comb begin
        partial = {remQ, dividendQ[DATA_W-1]};
        diff    = partial - {1'b0, divisorQ};
        if (!diff[DATA_W]) begin
            remNext = diff[DATA_W-1:0];
            quoNext = {dividendQ[DATA_W-2:0], 1'b1};
        end else begin
            remNext = partial[DATA_W-1:0];
            quoNext = {dividendQ[DATA_W-2:0], 1'b0};
        end
    end

    always_comb begin
        stateD    = stateQ;
        cntD      = cntQ;
        dividendD = dividendQ;
        divisorD  = divisorQ;
        remD      = remQ;
        quoNegD   = quoNegQ;
        remNegD   = remNegQ;
        resultD   = resultQ;

        unique case (stateQ)
            StIdle: begin
                if (start_i) begin
                    stateD    = (opdata2_i == '0) ? StDivZero : StOn;
                    cntD      = '0;
                    dividendD = magnitude(opdata1_i, isSigned);
                    divisorD  = magnitude(opdata2_i, isSigned);
                    remD      = '0;
                    quoNegD   = isSigned & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                    remNegD   = isSigned & opdata1_i[DATA_W-1];
                end
            end
            StDivZero: begin
                stateD  = StEnd;
                resultD = '0;
            end
            StOn: begin
                cntD      = cntQ + 6'd1;
                dividendD = quoNext;
                remD      = remNext;
                if (cntQ == LastCnt) begin
                    stateD  = StEnd;
                    cntD    = '0;
                    resultD = {remNegQ ? negate(remNext) : remNext,
                               quoNegQ ? negate(quoNext) : quoNext};
                end
            end
            StEnd: begin
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase

        // Flush wins over everything, including a start in the same cycle.
        if (annul_i) begin
            stateD  = StIdle;
            cntD    = '0;
            resultD = resultQ;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= StIdle;
            cntQ      <= '0;
            dividendQ <= '0;
            divisorQ  <= '0;
            remQ      <= '0;
            quoNegQ   <= 1'b0;
            remNegQ   <= 1'b0;
            resultQ   <= '0;
        end else begin
            stateQ    <= stateD;
            cntQ      <= cntD;
            dividendQ <= dividendD;
            divisorQ  <= divisorD;
            remQ      <= remD;
            quoNegQ   <= quoNegD;
            remNegQ   <= remNegD;
            resultQ   <= resultD;
        end
    end

    assign ready_o  = (stateQ == StEnd) && !annul_i;
    assign result_o = resultQ;
    assign stall_o  = start_i & ~ready_o;

endmodule

// File: tb/tb_mdu_div.sv
// Directed and random checks of mdu_div against a plain-arithmetic division model.
module tb_mdu_div;
    import mdu_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic        annul_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_o;

    int nChecks = 0;
    int nErrors = 0;

    mdu_div #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .signed_i  (signed_i),
        .annul_i   (annul_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .stall_o   (stall_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
        longint na, nb, q, r;
        if (b == 32'h0) return 64'h0;
        na = {{32{a[31] & s}}, a};
        nb = {{32{b[31] & s}}, b};
        q  = na / nb;
        r  = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered just after a rising edge with the divider idle; leaves it the same way.
    task automatic runDiv(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input string tag);
        logic [63:0] exp;
        int          lat;
        int          expLat;
        exp       = refDiv(a, b, s);
        expLat    = (b == 32'h0) ? 2 : 33;
        opdata1_i = a;
        opdata2_i = b;
        signed_i  = s;
        start_i   = 1'b1;
        lat       = -1;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (ready_o) begin
                lat = k;
                break;
            end
            check({tag, " stall"}, 64'(stall_o), 64'd1);
            if (k == 1) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
                signed_i  = ~s;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(expLat));
        check({tag, " result"}, result_o, exp);
        check({tag, " stall@ready"}, 64'(stall_o), 64'd0);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(negedge clk);
        check({tag, " hold"}, result_o, exp);
        check({tag, " ready low"}, 64'(ready_o), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          sawReady;
        int          lowCnt;
        int          firstLat;
        int          secondLat;
        logic [31:0] ra, rb;
        logic        rs;

        rst       = 1'b1;
        start_i   = 1'b1;
        signed_i  = OpDivU;
        annul_i   = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        #2;
        check("reset result", result_o, 64'h0);
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset stall follows start hi", 64'(stall_o), 64'd1);
        start_i = 1'b0;
        #1;
        check("reset stall follows start lo", 64'(stall_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        runDiv(32'd100, 32'd7, OpDivU, "udiv 100/7");
        runDiv(32'hFFFFFFF9, 32'd2, OpDiv, "sdiv -7/2");
        runDiv(32'd7, 32'hFFFFFFFE, OpDiv, "sdiv 7/-2");
        runDiv(32'd5, 32'd0, OpDivU, "div 5/0");
        runDiv(32'hFFFFFFFF, 32'd3, OpDivU, "udiv max/3");
        runDiv(32'h80000000, 32'hFFFFFFFF, OpDiv, "sdiv overflow");

        // Reset in the middle of a divide: outputs clear at once and nothing completes.
        opdata1_i = 32'h12345678;
        opdata2_i = 32'h00001234;
        signed_i  = OpDivU;
        start_i   = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midop reset result", result_o, 64'h0);
        check("midop reset ready", 64'(ready_o), 64'd0);
        check("midop reset stall", 64'(stall_o), 64'd1);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        sawReady = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ready_o) sawReady++;
        end
        check("midop reset no ready", 64'(sawReady), 64'd0);
        check("midop reset result stays", result_o, 64'h0);
        @(posedge clk);
        #1;

        // Annul at cycle 10, idle at 11, fresh start at 12 must finish 33 cycles later.
        opdata1_i = 32'd1234;
        opdata2_i = 32'd5;
        signed_i  = OpDivU;
        start_i   = 1'b1;
        sawReady  = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 10) annul_i = 1'b1;
            if (k == 11) begin
                annul_i = 1'b0;
                start_i = 1'b0;
            end
            @(negedge clk);
            if (ready_o) sawReady++;
            @(posedge clk);
            #1;
        end
        check("annul no ready", 64'(sawReady), 64'd0);
        runDiv(32'd999, 32'd10, OpDivU, "after annul");

        // Annul and start together: the start must be dropped.
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        runDiv(32'd50, 32'd5, OpDivU, "annul priority");

        // Start held across END: second op accepted right after, stall drops only in END.
        opdata1_i = 32'd1000;
        opdata2_i = 32'd9;
        signed_i  = OpDivU;
        start_i   = 1'b1;
        lowCnt    = 0;
        firstLat  = -1;
        secondLat = -1;
        for (int k = 0; k <= 80; k++) begin
            @(negedge clk);
            if (!stall_o) lowCnt++;
            if (ready_o && firstLat < 0) begin
                firstLat = k;
                check("b2b first result", result_o, refDiv(32'd1000, 32'd9, OpDivU));
                opdata1_i = 32'd77777;
                opdata2_i = 32'd3;
            end else if (ready_o) begin
                secondLat = k;
                break;
            end
        end
        check("b2b first latency", 64'(firstLat), 64'd33);
        check("b2b second latency", 64'(secondLat), 64'd67);
        check("b2b stall low cycles", 64'(lowCnt), 64'd2);
        check("b2b second result", result_o, refDiv(32'd77777, 32'd3, OpDivU));
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       rb = 32'h0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFFFFFF;
                3: begin
                    ra = 32'h80000000;
                    rb = $urandom;
                end
                4:       rb = {16'h0, 16'($urandom)};
                default: rb = $urandom;
            endcase
            runDiv(ra, rb, rs, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
